// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default framing constants shared by the UART transmitter and receiver
package uart_pkg;
   localparam int OVERSAMPLE  = 16;
   localparam int DBIT_DEF    = 8;
   localparam int SB_TICK_DEF = 16;
   typedef logic [2:0] state_t;
   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, start/DBIT data LSB first/stop; define UART_TX_PARITY_EN to insert an even parity bit
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_ticks,
   input  logic            i_tx_start,
   input  logic [DBIT-1:0] i_data_byte,
   output logic            o_tx,
   output logic            o_tx_busy,
   output logic            o_tx_done
);
   localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DBIT);
   state_t          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] sh_q, sh_d;
   logic            tx_q, tx_d;
   logic            bit_end, done;
`ifdef UART_TX_PARITY_EN
   logic            par_q;
`endif
   assign bit_end   = i_ticks && (s_q == SW'(OVERSAMPLE - 1));
   assign o_tx      = tx_q;
   assign o_tx_busy = (state_q != IDLE);
   assign o_tx_done = done;
   // next-state: tick counter runs on every tick, each state leaves on its final tick
   always_comb begin
      state_d = state_q;
      s_d     = i_ticks ? s_q + SW'(1) : s_q;
      n_d     = n_q;
      sh_d    = sh_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            s_d = '0;
            if (i_tx_start) begin
               state_d = START;
               sh_d    = i_data_byte;
            end
         end
         START: if (bit_end) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
         end
         DATA: if (bit_end) begin
            s_d  = '0;
            sh_d = sh_q >> 1;
            if (n_q == NW'(DBIT - 1))
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            else
               n_d = n_q + NW'(1);
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            s_d     = '0;
            state_d = STOP;
         end
`endif
         STOP: if (i_ticks && s_q == SW'(SB_TICK - 1)) begin
            s_d     = '0;
            state_d = IDLE;
            done    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // line level follows the state being entered so o_tx can be a plain flop
   always_comb begin
      tx_d = (state_d == START) ? 1'b0 :
             (state_d == DATA)  ? sh_d[0] :
`ifdef UART_TX_PARITY_EN
             (state_d == PARITY) ? par_q :
`endif
             1'b1;
   end
   // state, counters, shift register and line flop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
      end
   end
`ifdef UART_TX_PARITY_EN
   // even parity of the accepted byte, captured alongside the shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= 1'b0;
      else if (state_q == IDLE && i_tx_start) par_q <= ^i_data_byte;
   end
`endif
endmodule
